// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the CPU (MEM stage), DMA/loader and datamem
// signals shared by the data-memory arbiter.
//   cpu_*  : MEM-stage request (req/wr/addr/wdata in, rdata/stall out)
//   dma_*  : DMA request (req/wr/addr/wdata in, gnt/rdata out)
//   dm_*   : datamem side (address/enables/write_data out, read_data in)
// slave  = arbiter view, master = environment view (pipeline + DMA + datamem).
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_wr;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic [63:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_wr;
  logic [63:0] dma_addr;
  logic [63:0] dma_wdata;
  logic        dma_gnt;
  logic [63:0] dma_rdata;

  logic [63:0] dm_address;
  logic        dm_write_enable;
  logic        dm_read_enable;
  logic [63:0] dm_write_data;
  logic [63:0] dm_read_data;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  dma_req, dma_wr, dma_addr, dma_wdata,
    input  dm_read_data,
    output cpu_rdata, cpu_stall, dma_gnt, dma_rdata,
    output dm_address, dm_write_enable, dm_read_enable, dm_write_data
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output dma_req, dma_wr, dma_addr, dma_wdata,
    output dm_read_data,
    input  cpu_rdata, cpu_stall, dma_gnt, dma_rdata,
    input  dm_address, dm_write_enable, dm_read_enable, dm_write_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: picks one owner of datamem per cycle between the MEM stage
// (CPU) and the DMA/loader port. CPU has priority; a blocked DMA request that
// has waited STARVE_LIMIT cycles wins once, then holds memory for up to
// MAX_BURST beats. Grant is combinational from registered state + current
// requests, so the owner sees read data in the granted cycle.
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   bus              dmem_arbiter_if.slave (CPU, DMA and datamem signals)
//   stat_cpu_stalls  stalled-cycle count (0 unless DMEM_ARB_STATS_EN)
//   stat_dma_beats   DMA granted-beat count (0 unless DMEM_ARB_STATS_EN)
// Optional feature macro: DMEM_ARB_STATS_EN (saturating 32-bit statistics).
module dmem_arbiter #(
  parameter int MAX_BURST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset,
  dmem_arbiter_if.slave       bus,
  output logic [31:0]         stat_cpu_stalls,
  output logic [31:0]         stat_dma_beats
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  typedef enum logic {CPU_PRI, DMA_BURST} mode_e;

  mode_e          mode_q,   mode_d;
  logic [BW-1:0]  burst_q,  burst_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic           cpu_gnt,  dma_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= CPU_PRI;
      burst_q  <= '0;
      starve_q <= '0;
    end else begin
      mode_q   <= mode_d;
      burst_q  <= burst_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    burst_d  = burst_q;
    starve_d = starve_q;
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    case (mode_q)
      CPU_PRI: begin
        if (bus.dma_req && (!bus.cpu_req || starve_q == STARVE_MAX)) begin
          dma_gnt = 1'b1;
          // A single-beat burst never needs the burst mode.
          mode_d  = (MAX_BURST > 1) ? DMA_BURST : CPU_PRI;
          burst_d = BURST_ONE;
        end else if (bus.cpu_req) begin
          cpu_gnt = 1'b1;
        end
      end
      DMA_BURST: begin
        if (bus.dma_req && burst_q < BURST_MAX) begin
          dma_gnt = 1'b1;
          burst_d = burst_q + BURST_ONE;
        end else if (bus.cpu_req) begin
          cpu_gnt = 1'b1;
          mode_d  = CPU_PRI;
          burst_d = '0;
        end else if (bus.dma_req) begin
          // Burst exhausted but nobody else wants memory: start a new one.
          dma_gnt = 1'b1;
          burst_d = BURST_ONE;
        end else begin
          mode_d  = CPU_PRI;
          burst_d = '0;
        end
      end
      default: begin
        mode_d  = CPU_PRI;
        burst_d = '0;
      end
    endcase

    if (dma_gnt || !bus.dma_req)   starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + STARVE_ONE;

    // Reset is asynchronous for the outputs too: no grant while held.
    if (!reset) begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end
  end

  assign bus.dma_gnt         = dma_gnt;
  assign bus.cpu_stall       = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rdata       = bus.dm_read_data;
  assign bus.dma_rdata       = bus.dm_read_data;
  assign bus.dm_write_enable = (cpu_gnt & bus.cpu_wr) | (dma_gnt & bus.dma_wr);
  assign bus.dm_read_enable  = (cpu_gnt & ~bus.cpu_wr) | (dma_gnt & ~bus.dma_wr);
  assign bus.dm_address      = cpu_gnt ? bus.cpu_addr  : (dma_gnt ? bus.dma_addr  : 64'd0);
  assign bus.dm_write_data   = cpu_gnt ? bus.cpu_wdata : (dma_gnt ? bus.dma_wdata : 64'd0);

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cnt_q, beat_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      if (bus.cpu_stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (dma_gnt && beat_cnt_q != 32'hFFFF_FFFF)       beat_cnt_q  <= beat_cnt_q + 32'd1;
    end
  end

  assign stat_cpu_stalls = stall_cnt_q;
  assign stat_dma_beats  = beat_cnt_q;
`else
  assign stat_cpu_stalls = 32'd0;
  assign stat_dma_beats  = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus for dmem_arbiter with a behavioural
// arbitration model (run length of DMA grants, length of DMA wait) checked
// every negedge, plus hand-computed literal expectations per scenario.
module tb_dmem_arbiter;
  localparam int MAXB   = 4;
  localparam int STARVE = 8;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] stat_cpu_stalls, stat_dma_beats;

  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MAX_BURST(MAXB), .STARVE_LIMIT(STARVE)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .stat_cpu_stalls (stat_cpu_stalls),
    .stat_dma_beats  (stat_dma_beats)
  );

  // Simple datamem: same-cycle read, write on rising edge.
  logic [63:0] mem [16];
  always @(posedge clk) if (bus.dm_write_enable) mem[bus.dm_address[6:3]] <= bus.dm_write_data;
  assign bus.dm_read_data = bus.dm_read_enable ? mem[bus.dm_address[6:3]] : 64'd0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // run   : DMA grants in a row ending last cycle
  // waitc : cycles in a row DMA asked and was refused
  int              run   = 0;
  int              waitc = 0;
  longint unsigned m_stalls = 0, m_beats = 0;
  logic [63:0]     mm [logic [63:0]];
  logic            dwin, cwin, ewe, ere;
  logic [63:0]     ea, ed;

  function automatic logic [31:0] exp_stat(input longint unsigned v);
`ifdef DMEM_ARB_STATS_EN
    return v[31:0];
`else
    return 32'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("m_rst_dma_gnt", bus.dma_gnt, 0);
      chk("m_rst_we", bus.dm_write_enable, 0);
      chk("m_rst_re", bus.dm_read_enable, 0);
      chk("m_rst_addr", bus.dm_address, 0);
      chk("m_rst_stall", bus.cpu_stall, bus.cpu_req);
      run = 0; waitc = 0; m_stalls = 0; m_beats = 0;
    end else begin
      // DMA keeps memory while inside an unfinished burst; otherwise it needs
      // an idle CPU or to have waited long enough.
      dwin = bus.dma_req && (!bus.cpu_req || waitc >= STARVE ||
                             (run > 0 && (run % MAXB) != 0));
      cwin = bus.cpu_req && !dwin;
      ea   = cwin ? bus.cpu_addr  : (dwin ? bus.dma_addr  : 64'd0);
      ed   = cwin ? bus.cpu_wdata : (dwin ? bus.dma_wdata : 64'd0);
      ewe  = (cwin && bus.cpu_wr) || (dwin && bus.dma_wr);
      ere  = (cwin && !bus.cpu_wr) || (dwin && !bus.dma_wr);
      chk("m_dma_gnt", bus.dma_gnt, dwin);
      chk("m_cpu_stall", bus.cpu_stall, bus.cpu_req && !cwin);
      chk("m_we", bus.dm_write_enable, ewe);
      chk("m_re", bus.dm_read_enable, ere);
      chk("m_addr", bus.dm_address, ea);
      chk("m_wdata", bus.dm_write_data, ed);
      if (cwin && !bus.cpu_wr && mm.exists(bus.cpu_addr)) chk("m_cpu_rdata", bus.cpu_rdata, mm[bus.cpu_addr]);
      if (dwin && !bus.dma_wr && mm.exists(bus.dma_addr)) chk("m_dma_rdata", bus.dma_rdata, mm[bus.dma_addr]);
      chk("m_stat_stalls", stat_cpu_stalls, exp_stat(m_stalls));
      chk("m_stat_beats", stat_dma_beats, exp_stat(m_beats));
      if (ewe) mm[ea] = ed;
      run   = dwin ? run + 1 : 0;
      waitc = (bus.dma_req && !dwin) ? waitc + 1 : 0;
      if (bus.cpu_req && !cwin && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (dwin && m_beats < 64'hFFFF_FFFF) m_beats++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d);
    bus.cpu_req = r; bus.cpu_wr = w; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic dma(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d);
    bus.dma_req = r; bus.dma_wr = w; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  task automatic idle();
    cpu(0, 0, 64'd0, 64'd0);
    dma(0, 0, 64'd0, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: requests during reset
    cpu(1, 0, 64'h10, 64'd0);
    dma(1, 0, 64'h10, 64'd0);
    #2;
    chk("t1_dma_gnt", bus.dma_gnt, 0);
    chk("t1_we", bus.dm_write_enable, 0);
    chk("t1_re", bus.dm_read_enable, 0);
    chk("t1_stall", bus.cpu_stall, 1);
    @(posedge clk); #1 reset = 1'b1; #1;
    chk("t1_cpu_first", bus.cpu_stall, 0);
    chk("t1_dma_wait", bus.dma_gnt, 0);
    chk("t1_stat_stalls", stat_cpu_stalls, 0);
    chk("t1_stat_beats", stat_dma_beats, 0);
    cyc(); idle();

    // 2: CPU store then load
    cyc(); cpu(1, 1, 64'h10, 64'hDEAD); #1;
    chk("t2_we", bus.dm_write_enable, 1);
    chk("t2_addr", bus.dm_address, 64'h10);
    chk("t2_stall", bus.cpu_stall, 0);
    cyc(); cpu(1, 0, 64'h10, 64'd0); #1;
    chk("t2_rdata", bus.cpu_rdata, 64'hDEAD);
    cyc(); idle();

    // 3: contention -> starvation guard, then 4-beat burst
    for (int c = 0; c <= 12; c++) begin
      cyc(); cpu(1, 0, 64'h10, 64'd0); dma(1, 0, 64'h10, 64'd0); #1;
      chk($sformatf("t3_dma_gnt_c%0d", c), bus.dma_gnt, (c >= 8 && c <= 11));
      chk($sformatf("t3_stall_c%0d", c), bus.cpu_stall, (c >= 8 && c <= 11));
    end
    cyc(); idle();

    // 4: DMA alone, 6 read beats across a burst restart
    for (int b = 0; b < 6; b++) begin
      cyc(); dma(1, 0, 64'h10, 64'd0); #1;
      chk($sformatf("t4_gnt_b%0d", b), bus.dma_gnt, 1);
      chk($sformatf("t4_rdata_b%0d", b), bus.dma_rdata, 64'hDEAD);
    end
    cyc(); idle();

    // 5: dma_req drops after beat 2 with CPU waiting
    cyc(); dma(1, 1, 64'h18, 64'hBEEF); #1;
    chk("t5_b1_gnt", bus.dma_gnt, 1);
    chk("t5_b1_wdata", bus.dm_write_data, 64'hBEEF);
    cyc(); cpu(1, 0, 64'h18, 64'd0); dma(1, 1, 64'h20, 64'h1234); #1;
    chk("t5_b2_gnt", bus.dma_gnt, 1);
    chk("t5_b2_stall", bus.cpu_stall, 1);
    cyc(); dma(0, 0, 64'd0, 64'd0); #1;
    chk("t5_cpu_stall", bus.cpu_stall, 0);
    chk("t5_cpu_rdata", bus.cpu_rdata, 64'hBEEF);
    cyc(); dma(1, 0, 64'h10, 64'd0); #1;
    chk("t5_cpu_pri_stall", bus.cpu_stall, 0);
    chk("t5_cpu_pri_gnt", bus.dma_gnt, 0);
    cyc(); idle();

    // 6: async reset mid-burst
    cyc(); dma(1, 0, 64'h10, 64'd0); #1;
    chk("t6_b1_gnt", bus.dma_gnt, 1);
    cyc(); #1;
    chk("t6_b2_gnt", bus.dma_gnt, 1);
    #1 reset = 1'b0; #1;
    chk("t6_async_gnt", bus.dma_gnt, 0);
    chk("t6_async_re", bus.dm_read_enable, 0);
    chk("t6_async_addr", bus.dm_address, 0);
    @(posedge clk); #1 reset = 1'b1;
    cpu(1, 0, 64'h20, 64'd0); dma(1, 0, 64'h10, 64'd0); #1;
    chk("t6_cpu_wins", bus.cpu_stall, 0);
    chk("t6_dma_waits", bus.dma_gnt, 0);
    chk("t6_cpu_rdata", bus.cpu_rdata, 64'h1234);
    chk("t6_stat_stalls", stat_cpu_stalls, 0);
    chk("t6_stat_beats", stat_dma_beats, 0);
    cyc(); idle();
    cyc();
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
